// File: rtl/dsi_video_sequencer.sv
// Video-mode packet sequencer for the DSI assembler: per-line sync, RGB888 and blanking packets.
// Optional DSI_VSE_EN: the first line after vertical sync opens with VSE instead of HSS.
module dsi_video_sequencer #(
  parameter int unsigned g_pixels_per_clock = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic [11:0] h_active_i,
  input  logic [15:0] h_blank_i,
  input  logic [11:0] h_lp_i,
  input  logic [11:0] v_sync_i,
  input  logic [11:0] v_back_i,
  input  logic [11:0] v_active_i,
  input  logic [11:0] v_front_i,
  output logic        p_req_o,
  output logic        p_islong_o,
  output logic [5:0]  p_type_o,
  output logic [15:0] p_wcount_o,
  output logic [15:0] p_command_o,
  output logic        p_last_o,
  input  logic        p_dreq_i,
  output logic        pix_req_o,
  output logic        blank_o,
  output logic        frame_start_o
);

  localparam logic [15:0] BeatBytes = 16'(3 * g_pixels_per_clock);
  localparam logic [5:0]  TypeVss   = 6'h01;
  localparam logic [5:0]  TypeHss   = 6'h21;
  localparam logic [5:0]  TypeRgb   = 6'h3e;
  localparam logic [5:0]  TypeBlank = 6'h19;

  typedef enum logic [2:0] {
    StIdle,
    StGap,
    StSyncHdr,
    StRgbHdr,
    StRgbPay,
    StBlankHdr,
    StBlankPay
  } state_e;

  state_e      state_q;
  logic [15:0] line_cnt_q;
  logic [15:0] beat_cnt_q;
  logic [11:0] gap_cnt_q;
  logic        p_req_q;
  logic        p_islong_q;
  logic [5:0]  p_type_q;
  logic [15:0] p_wcount_q;
  logic        p_last_q;

  logic [15:0] act_first;
  logic [15:0] act_end;
  logic [15:0] total_lines;
  logic [15:0] rgb_bytes;
  logic [15:0] pay_beats;
  logic        line_active;
  logic        last_line;
  logic        accept;
  logic        start_line;
  logic [5:0]  sync_type;

  always_comb begin
    act_first   = {4'd0, v_sync_i} + {4'd0, v_back_i};
    act_end     = act_first + {4'd0, v_active_i};
    total_lines = act_end + {4'd0, v_front_i};
    rgb_bytes   = {4'd0, h_active_i} * 16'd3;
    pay_beats   = p_wcount_q / BeatBytes;
    line_active = (line_cnt_q >= act_first) && (line_cnt_q < act_end);
    last_line   = (line_cnt_q == total_lines - 16'd1);
    accept      = p_req_q & p_dreq_i;
    // A new line may only begin from IDLE or on the final LP gap cycle.
    start_line  = enable_i && ((state_q == StIdle) || (state_q == StGap && gap_cnt_q == 12'd1));
    sync_type   = TypeHss;
    if (line_cnt_q == 16'd0) begin
      sync_type = TypeVss;
`ifdef DSI_VSE_EN
    end else if (line_cnt_q == {4'd0, v_sync_i}) begin
      sync_type = 6'h11;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      line_cnt_q <= '0;
      beat_cnt_q <= '0;
      gap_cnt_q  <= '0;
      p_req_q    <= 1'b0;
      p_islong_q <= 1'b0;
      p_type_q   <= '0;
      p_wcount_q <= '0;
      p_last_q   <= 1'b0;
    end else if (start_line) begin
      state_q    <= StSyncHdr;
      gap_cnt_q  <= '0;
      p_req_q    <= 1'b1;
      p_islong_q <= 1'b0;
      p_type_q   <= sync_type;
      p_wcount_q <= '0;
      p_last_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StGap: begin
          gap_cnt_q <= gap_cnt_q - 12'd1;
          if (gap_cnt_q == 12'd1) state_q <= StIdle;
        end
        StSyncHdr: begin
          if (accept) begin
            p_islong_q <= 1'b1;
            if (line_active) begin
              state_q    <= StRgbHdr;
              p_type_q   <= TypeRgb;
              p_wcount_q <= rgb_bytes;
              p_last_q   <= 1'b0;
            end else begin
              state_q    <= StBlankHdr;
              p_type_q   <= TypeBlank;
              p_wcount_q <= rgb_bytes + h_blank_i;
              p_last_q   <= 1'b1;
            end
          end
        end
        StRgbHdr, StBlankHdr: begin
          if (accept) begin
            beat_cnt_q <= pay_beats;
            state_q    <= (state_q == StRgbHdr) ? StRgbPay : StBlankPay;
          end
        end
        StRgbPay: begin
          if (p_dreq_i) begin
            beat_cnt_q <= beat_cnt_q - 16'd1;
            if (beat_cnt_q == 16'd1) begin
              state_q    <= StBlankHdr;
              p_type_q   <= TypeBlank;
              p_wcount_q <= h_blank_i;
              p_last_q   <= 1'b1;
            end
          end
        end
        StBlankPay: begin
          if (p_dreq_i) begin
            beat_cnt_q <= beat_cnt_q - 16'd1;
            if (beat_cnt_q == 16'd1) begin
              state_q    <= StGap;
              p_req_q    <= 1'b0;
              gap_cnt_q  <= h_lp_i;
              line_cnt_q <= last_line ? 16'd0 : line_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign p_req_o       = p_req_q;
  assign p_islong_o    = p_islong_q;
  assign p_type_o      = p_type_q;
  assign p_wcount_o    = p_wcount_q;
  assign p_command_o   = '0;
  assign p_last_o      = p_last_q;
  assign pix_req_o     = p_dreq_i & (state_q == StRgbPay);
  assign blank_o       = (state_q != StRgbPay);
  assign frame_start_o = accept & (state_q == StSyncHdr) & (p_type_q == TypeVss);

endmodule

// File: tb/tb_dsi_video_sequencer.sv
// Bench for dsi_video_sequencer: random p_dreq_i stalls checked against a line-level packet model.
// Compile with +define+DSI_VSE_EN to check the VSE variant.
module tb_dsi_video_sequencer;
  localparam int Ppc = 1;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        enable_i;
  logic [11:0] h_active_i, h_lp_i, v_sync_i, v_back_i, v_active_i, v_front_i;
  logic [15:0] h_blank_i;
  logic        p_dreq_i;
  logic        p_req_o, p_islong_o, p_last_o, pix_req_o, blank_o, frame_start_o;
  logic [5:0]  p_type_o;
  logic [15:0] p_wcount_o, p_command_o;

  dsi_video_sequencer #(.g_pixels_per_clock(Ppc)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .enable_i(enable_i),
    .h_active_i(h_active_i), .h_blank_i(h_blank_i), .h_lp_i(h_lp_i),
    .v_sync_i(v_sync_i), .v_back_i(v_back_i), .v_active_i(v_active_i), .v_front_i(v_front_i),
    .p_req_o(p_req_o), .p_islong_o(p_islong_o), .p_type_o(p_type_o), .p_wcount_o(p_wcount_o),
    .p_command_o(p_command_o), .p_last_o(p_last_o), .p_dreq_i(p_dreq_i),
    .pix_req_o(pix_req_o), .blank_o(blank_o), .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int duty = 100;
  int vs, vb, va, vf, ha, hb, lp;
  int pix_cnt = 0, fs_cnt = 0, viol = 0, vss_seen = 0;
  bit pending = 0;
  logic       s_req, s_islong, s_last, s_pix, s_fs, s_dreq;
  logic [5:0] s_type;
  logic [15:0] s_wc, s_cmd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int s, input int b, input int a, input int f,
                         input int h, input int bl, input int g);
    vs = s; vb = b; va = a; vf = f; ha = h; hb = bl; lp = g;
    v_sync_i = 12'(s); v_back_i = 12'(b); v_active_i = 12'(a); v_front_i = 12'(f);
    h_active_i = 12'(h); h_blank_i = 16'(bl); h_lp_i = 12'(g);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"}, p_req_o, 0);
    chk({tag, "_islong"}, p_islong_o, 0);
    chk({tag, "_type"}, p_type_o, 0);
    chk({tag, "_wcount"}, p_wcount_o, 0);
    chk({tag, "_cmd"}, p_command_o, 0);
    chk({tag, "_last"}, p_last_o, 0);
    chk({tag, "_pix"}, pix_req_o, 0);
    chk({tag, "_blank"}, blank_o, 1);
    chk({tag, "_fs"}, frame_start_o, 0);
  endtask

  // One clock: drive p_dreq_i on the falling edge, sample just after it.
  task automatic step();
    @(negedge clk);
    p_dreq_i = ($urandom_range(99) < duty);
    #1;
    s_req = p_req_o; s_islong = p_islong_o; s_last = p_last_o; s_pix = pix_req_o;
    s_fs = frame_start_o; s_dreq = p_dreq_i; s_type = p_type_o; s_wc = p_wcount_o;
    s_cmd = p_command_o;
    if (s_pix && !s_dreq) viol++;
    if (s_pix) pix_cnt++;
    if (s_fs) fs_cnt++;
  endtask

  task automatic wait_dreq(output bit ok);
    ok = 1;
    if (pending) begin
      pending = 0;
      return;
    end
    for (int n = 0; n < 1000; n++) begin
      step();
      if (s_dreq) return;
    end
    ok = 0;
    tests++;
    fails++;
    $error("FAIL dreq_timeout: observed no accept cycle, required one");
  endtask

  function automatic int sync_type(input int l);
    if (l == 0) return 'h01;
`ifdef DSI_VSE_EN
    if (l == vs) return 'h11;
`endif
    return 'h21;
  endfunction

  task automatic expect_hdr(input string tag, input int exp_type, input int wc, input int last,
                            input int is_long, input bit vss);
    bit ok;
    wait_dreq(ok);
    if (!ok) return;
    chk({tag, "_req"}, s_req, 1);
    chk({tag, "_type"}, s_type, exp_type);
    chk({tag, "_islong"}, s_islong, is_long);
    chk({tag, "_last"}, s_last, last);
    chk({tag, "_cmd"}, s_cmd, 0);
    if (is_long != 0) chk({tag, "_wcount"}, s_wc, wc);
    else begin
      chk({tag, "_frame_start"}, s_fs, vss);
      if (vss) vss_seen++;
    end
  endtask

  task automatic expect_beats(input string tag, input int n, input int rgb, input int drop_at);
    bit ok;
    for (int k = 0; k < n; k++) begin
      wait_dreq(ok);
      if (!ok) return;
      chk({tag, "_beat_req"}, s_req, 1);
      chk({tag, "_beat_pix"}, s_pix, rgb);
      if (k == drop_at) enable_i = 1'b0;
    end
  endtask

  // Model of one line: packet list derived from the line index and region sizes.
  task automatic check_line(input int l, input int drop_at);
    int p0, wc;
    bit act;
    p0  = pix_cnt;
    act = (l >= vs + vb) && (l < vs + vb + va);
    expect_hdr("sync", sync_type(l), 0, 0, 0, l == 0);
    if (act) begin
      expect_hdr("rgb", 'h3e, 3 * ha, 0, 1, 0);
      expect_beats("rgb", ha / Ppc, 1, drop_at);
      expect_hdr("blank_act", 'h19, hb, 1, 1, 0);
      expect_beats("blank_act", hb / (3 * Ppc), 0, -1);
    end else begin
      wc = (3 * ha + hb) % 65536;
      expect_hdr("blank", 'h19, wc, 1, 1, 0);
      expect_beats("blank", wc / (3 * Ppc), 0, -1);
    end
    chk("line_pix", pix_cnt - p0, act ? ha / Ppc : 0);
  endtask

  task automatic check_gap(input int exp);
    int cnt = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      if (s_req) begin
        pending = s_dreq;
        break;
      end
      cnt++;
    end
    chk("gap_len", cnt, exp);
  endtask

  task automatic run_frame();
    int p0 = pix_cnt;
    for (int l = 0; l < vs + vb + va + vf; l++) begin
      check_line(l, -1);
      check_gap(lp);
    end
    chk("frame_pix", pix_cnt - p0, va * ha / Ppc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int hi;
    set_cfg(1, 1, 2, 1, 4, 6, 3);
    enable_i = 1'b0;
    p_dreq_i = 1'b1;
    rst_n_i  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n_i = 1'b1;
    step();
    chk("idle_req", s_req, 0);
    enable_i = 1'b1;
    step();
    chk("req_rise", s_req, 1);
    pending = s_dreq;

    duty = 100;
    run_frame();
    run_frame();

    duty = 30;
    run_frame();

    // Drop enable_i during RGB payload of line 2; the line must still finish.
    duty = 50;
    check_line(0, -1);
    check_gap(lp);
    check_line(1, -1);
    check_gap(lp);
    check_line(2, 1);
    hi = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (s_req) hi++;
    end
    chk("drop_idle_req", hi, 0);

    // Resume at line 3 then reset in the middle of its RGB payload.
    enable_i = 1'b1;
    step();
    chk("req_rise2", s_req, 1);
    pending = s_dreq;
    expect_hdr("resume_sync", sync_type(3), 0, 0, 0, 0);
    expect_hdr("resume_rgb", 'h3e, 3 * ha, 0, 1, 0);
    expect_beats("resume_rgb", 2, 1, -1);
    @(negedge clk);
    p_dreq_i = 1'b1;
    rst_n_i  = 1'b0;
    #1;
    chk_reset("midline_reset");
    pending = 0;
    @(negedge clk);
    rst_n_i = 1'b1;
    check_line(0, -1);
    check_gap(lp);

    // Second configuration without back porch.
    @(negedge clk);
    rst_n_i  = 1'b0;
    enable_i = 1'b0;
    set_cfg(1, 0, 2, 1, 6, 9, 2);
    @(negedge clk);
    rst_n_i  = 1'b1;
    enable_i = 1'b1;
    pending  = 0;
    run_frame();

    chk("pix_without_dreq", viol, 0);
    chk("frame_start_total", fs_cnt, vss_seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
